data_mem_arbiter: RTL and testbench
===================================

// Module: data_mem_arbiter
// PURPOSE
//  Shares one data_memory instance between two requesters: port 0 = core load/store
//  unit (priority), port 1 = DMA/program loader. Serialises requests, drives the
//  memory strobes one access at a time, and returns read data with a valid pulse.
//  Starvation guard forces a port-1 grant after STARVE_LIMIT consecutive port-0 wins.
// PARAMETERS
//  ADDR_W        32  address width, byte addressed, passed through unchanged
//  DATA_W        32  data width; byte_enable width is DATA_W/8
//  READ_LATENCY  1   cycles from mem_read_en to valid mem_data_out (>=1)
//  STARVE_LIMIT  4   consecutive port-0 grants with p1_req pending before port 1 is forced
// PORTS
//  clk              in   1         system clock, rising edge
//  reset            in   1         asynchronous, active-low reset
//  pN_req           in   1         (N=0,1) request; held with fields stable until pN_gnt
//  pN_we            in   1         1 = store, 0 = load
//  pN_addr          in   ADDR_W    byte address
//  pN_wdata         in   DATA_W    store data, lane-aligned
//  pN_be            in   DATA_W/8  byte enables (also selects load size)
//  pN_gnt           out  1         one-cycle pulse: request accepted, may drop req
//  pN_rvalid        out  1         one-cycle pulse: pN_rdata valid for this port's load
//  pN_rdata         out  DATA_W    load data, held until that port's next rvalid
//  mem_addr         out  ADDR_W    to data_memory.addr
//  mem_data_in      out  DATA_W    to data_memory.data_in
//  mem_read_en      out  1         to data_memory.read_en
//  mem_write_en     out  1         to data_memory.write_en
//  mem_byte_enable  out  DATA_W/8  to data_memory.byte_enable
//  mem_data_out     in   DATA_W    from data_memory.data_out
//  busy             out  1         high in every state except IDLE
// BEHAVIOUR
//  - Reset (reset=0, async): state IDLE, all outputs 0, starve counter 0, owner 0.
//    Reset mid-transaction aborts it: no gnt/rvalid issued, memory strobes drop at once.
//  - FSM: IDLE -> GRANT -> (load) WAIT -> RESP -> IDLE ; (store) GRANT -> IDLE.
//  - IDLE: at each edge, if any req: pick winner, register its addr/wdata/be/we and
//    owner; next state GRANT. No req: stay.
//  - Winner: p1 if p1_req && (!p0_req || starve==STARVE_LIMIT); else p0.
//  - GRANT (1 cycle): owner gnt=1; mem_addr/mem_byte_enable/mem_data_in from registers;
//    mem_write_en=we, mem_read_en=!we. Store: memory writes this edge -> IDLE.
//  - WAIT: READ_LATENCY cycles, strobes low, mem_addr/byte_enable held. On last WAIT
//    edge capture mem_data_out into owner's rdata register -> RESP.
//  - RESP (1 cycle): owner rvalid=1 -> IDLE. Other port's rdata/rvalid untouched.
//  - Latency: req seen at edge T -> gnt in cycle T+1; load rvalid in cycle
//    T+2+READ_LATENCY. Store throughput 1 per 2 cycles, load 1 per 3+READ_LATENCY.
//  - Starve counter (0..STARVE_LIMIT, saturating): +1 when p0 granted while p1_req=1;
//    cleared when p1 granted or when p1_req=0 in IDLE.
//  - Simultaneous req with counter below limit: p0 wins. Requests arriving outside IDLE
//    wait; a req dropped before gnt is a protocol error (behaviour undefined).
//  - No sign extension or lane shifting here; data_memory handles it.
//  - mem_read_en and mem_write_en never high together; never high outside GRANT.
// TESTING
//  1 p0 store addr=0x08 data=0xDEADBEEF be=1111 -> p0_gnt 1 cycle after req,
//    mem_write_en 1 cycle, debug read 0x08 = 0xDEADBEEF, busy back low next cycle.
//  2 p1 load addr=0x08 be=1111, READ_LATENCY=1 -> p1_rvalid 3 cycles after req edge,
//    p1_rdata=0xDEADBEEF; p0_rvalid stays 0, p0_rdata unchanged.
//  3 p0_req and p1_req raised same cycle, counter 0 -> p0_gnt first, p1_gnt on the
//    next IDLE pass; mem_addr carries p0 addr then p1 addr.
//  4 p0_req held continuously (stores), p1_req held -> after 4 p0 grants, 5th grant
//    goes to p1; counter reads 0 afterwards.
//  5 p1 load addr=0x09 be=0001 after store in 1 -> p1_rdata=0xFFFFFFBE (memory sign
//    extension passed through unchanged).
//  6 reset low during WAIT of a p0 load -> strobes/busy 0 immediately, no p0_rvalid;
//    after release, new p0 load completes normally.

Source files
------------

// File: rtl/data_mem_arbiter.sv
// Two-port arbiter for one data memory: port 0 has priority, port 1 is forced through after STARVE_LIMIT
// consecutive port-0 wins. gnt 1 cycle after the request edge, load rvalid at 2+READ_LATENCY; requests wait while busy.
module data_mem_arbiter #(
   parameter int ADDR_W       = 32,
   parameter int DATA_W       = 32,
   parameter int READ_LATENCY = 1,
   parameter int STARVE_LIMIT = 4
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                p0_req,
   input  logic                p0_we,
   input  logic [ADDR_W-1:0]   p0_addr,
   input  logic [DATA_W-1:0]   p0_wdata,
   input  logic [DATA_W/8-1:0] p0_be,
   output logic                p0_gnt,
   output logic                p0_rvalid,
   output logic [DATA_W-1:0]   p0_rdata,
   input  logic                p1_req,
   input  logic                p1_we,
   input  logic [ADDR_W-1:0]   p1_addr,
   input  logic [DATA_W-1:0]   p1_wdata,
   input  logic [DATA_W/8-1:0] p1_be,
   output logic                p1_gnt,
   output logic                p1_rvalid,
   output logic [DATA_W-1:0]   p1_rdata,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic [DATA_W-1:0]   mem_data_in,
   output logic                mem_read_en,
   output logic                mem_write_en,
   output logic [DATA_W/8-1:0] mem_byte_enable,
   input  logic [DATA_W-1:0]   mem_data_out,
   output logic                busy
);

   localparam int BE_W   = DATA_W / 8;
   localparam int CNT_W  = $clog2(STARVE_LIMIT + 1);
   localparam int WAIT_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

   localparam logic [CNT_W-1:0]  STARVE_MAX = CNT_W'(STARVE_LIMIT);
   localparam logic [WAIT_W-1:0] WAIT_LAST  = WAIT_W'(READ_LATENCY - 1);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_GRANT = 2'd1;
   localparam logic [1:0] S_WAIT  = 2'd2;
   localparam logic [1:0] S_RESP  = 2'd3;

   logic [1:0]        state;
   logic              owner;
   logic              r_we;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_wdata;
   logic [BE_W-1:0]   r_be;
   logic [CNT_W-1:0]  starve_cnt;
   logic [WAIT_W-1:0] wait_cnt;
   logic [DATA_W-1:0] p0_rdata_q;
   logic [DATA_W-1:0] p1_rdata_q;
   logic              pick_p1;

   assign pick_p1 = p1_req && (!p0_req || (starve_cnt == STARVE_MAX));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= S_IDLE;
         owner      <= 1'b0;
         r_we       <= 1'b0;
         r_addr     <= '0;
         r_wdata    <= '0;
         r_be       <= '0;
         starve_cnt <= '0;
         wait_cnt   <= '0;
         p0_rdata_q <= '0;
         p1_rdata_q <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (!p1_req)
                  starve_cnt <= '0;
               if (p0_req || p1_req) begin
                  state <= S_GRANT;
                  owner <= pick_p1;
                  if (pick_p1) begin
                     r_we       <= p1_we;
                     r_addr     <= p1_addr;
                     r_wdata    <= p1_wdata;
                     r_be       <= p1_be;
                     starve_cnt <= '0;
                  end else begin
                     r_we    <= p0_we;
                     r_addr  <= p0_addr;
                     r_wdata <= p0_wdata;
                     r_be    <= p0_be;
                     // Only wins taken while port 1 is waiting count toward starvation.
                     if (p1_req && (starve_cnt != STARVE_MAX))
                        starve_cnt <= starve_cnt + 1'b1;
                  end
               end
            end
            S_GRANT: begin
               if (r_we) begin
                  state <= S_IDLE;
               end else begin
                  state    <= S_WAIT;
                  wait_cnt <= WAIT_LAST;
               end
            end
            S_WAIT: begin
               if (wait_cnt == '0) begin
                  state <= S_RESP;
                  if (owner)
                     p1_rdata_q <= mem_data_out;
                  else
                     p0_rdata_q <= mem_data_out;
               end else begin
                  wait_cnt <= wait_cnt - 1'b1;
               end
            end
            S_RESP:  state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

   // Outputs decode straight from state so an async reset drops strobes immediately.
   assign p0_gnt          = (state == S_GRANT) && !owner;
   assign p1_gnt          = (state == S_GRANT) &&  owner;
   assign p0_rvalid       = (state == S_RESP)  && !owner;
   assign p1_rvalid       = (state == S_RESP)  &&  owner;
   assign p0_rdata        = p0_rdata_q;
   assign p1_rdata        = p1_rdata_q;
   assign mem_addr        = r_addr;
   assign mem_data_in     = r_wdata;
   assign mem_byte_enable = r_be;
   assign mem_write_en    = (state == S_GRANT) &&  r_we;
   assign mem_read_en     = (state == S_GRANT) && !r_we;
   assign busy            = (state != S_IDLE);

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter with a small sign-extending data memory model (READ_LATENCY=1).
module tb_data_mem_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        p0_req, p0_we, p1_req, p1_we;
   logic [31:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
   logic [3:0]  p0_be, p1_be;
   logic        p0_gnt, p0_rvalid, p1_gnt, p1_rvalid;
   logic [31:0] p0_rdata, p1_rdata;
   logic [31:0] mem_addr, mem_data_in, mem_data_out;
   logic        mem_read_en, mem_write_en, busy;
   logic [3:0]  mem_byte_enable;

   logic [31:0] mem [0:63];
   int          n_checks = 0;
   int          n_pass   = 0;
   logic        g0, g1, ok;

   always #5 clk = ~clk;

   data_mem_arbiter dut (
      .clk(clk), .reset(reset),
      .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata), .p0_be(p0_be),
      .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
      .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata), .p1_be(p1_be),
      .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
      .mem_addr(mem_addr), .mem_data_in(mem_data_in), .mem_read_en(mem_read_en),
      .mem_write_en(mem_write_en), .mem_byte_enable(mem_byte_enable),
      .mem_data_out(mem_data_out), .busy(busy)
   );

   // Memory model: lane-aligned byte-enable writes; loads sign-extend by size (be) at lane addr[1:0].
   function automatic logic [31:0] load_fn(input logic [31:0] a, input logic [3:0] be);
      logic [31:0] w;
      logic [7:0]  b;
      logic [15:0] h;
      w = mem[a[7:2]];
      b = w[8*int'(a[1:0]) +: 8];
      h = w[16*int'(a[1]) +: 16];
      case (be)
         4'b0001: return {{24{b[7]}}, b};
         4'b0011: return {{16{h[15]}}, h};
         default: return w;
      endcase
   endfunction

   always @(posedge clk) begin
      if (mem_write_en)
         for (int i = 0; i < 4; i++)
            if (mem_byte_enable[i]) mem[mem_addr[7:2]][8*i +: 8] <= mem_data_in[8*i +: 8];
      if (mem_read_en)
         mem_data_out <= load_fn(mem_addr, mem_byte_enable);
   end

   task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_gnt(output logic o_g0, output logic o_g1, output logic o_ok);
      o_g0 = 1'b0; o_g1 = 1'b0; o_ok = 1'b0;
      for (int c = 0; c < 8; c++) begin
         tick();
         if (p0_gnt || p1_gnt) begin
            o_g0 = p0_gnt; o_g1 = p1_gnt; o_ok = 1'b1;
            break;
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      for (int i = 0; i < 64; i++) mem[i] = 32'h0;
      mem_data_out = 32'h0;
      reset = 1'b0;
      p0_req = 0; p0_we = 0; p0_addr = 0; p0_wdata = 0; p0_be = 0;
      p1_req = 0; p1_we = 0; p1_addr = 0; p1_wdata = 0; p1_be = 0;
      #3;
      check_val("rst_busy", busy, 0);
      check_val("rst_strobes", {mem_read_en, mem_write_en, p0_gnt, p1_gnt, p0_rvalid, p1_rvalid}, 0);
      check_val("rst_mem_addr", mem_addr, 0);
      check_val("rst_p0_rdata", p0_rdata, 0);
      tick(); tick();
      reset = 1'b1;

      // 1: p0 store
      tick();
      p0_req = 1; p0_we = 1; p0_addr = 32'h08; p0_wdata = 32'hDEADBEEF; p0_be = 4'hF;
      tick();
      check_val("t1_p0_gnt", p0_gnt, 1);
      check_val("t1_write_en", mem_write_en, 1);
      check_val("t1_read_en", mem_read_en, 0);
      check_val("t1_mem_addr", mem_addr, 32'h08);
      check_val("t1_mem_data_in", mem_data_in, 32'hDEADBEEF);
      check_val("t1_busy", busy, 1);
      p0_req = 0;
      tick();
      check_val("t1_busy_low", busy, 0);
      check_val("t1_write_en_low", mem_write_en, 0);
      check_val("t1_p0_gnt_low", p0_gnt, 0);
      check_val("t1_mem_word", mem[2], 32'hDEADBEEF);

      // 2: p1 word load
      p1_req = 1; p1_we = 0; p1_addr = 32'h08; p1_be = 4'hF;
      tick();
      check_val("t2_p1_gnt", p1_gnt, 1);
      check_val("t2_read_en", mem_read_en, 1);
      check_val("t2_write_en", mem_write_en, 0);
      p1_req = 0;
      tick();
      check_val("t2_wait_read_en", mem_read_en, 0);
      check_val("t2_wait_rvalid", p1_rvalid, 0);
      check_val("t2_wait_addr", mem_addr, 32'h08);
      tick();
      check_val("t2_p1_rvalid", p1_rvalid, 1);
      check_val("t2_p1_rdata", p1_rdata, 32'hDEADBEEF);
      check_val("t2_p0_rvalid", p0_rvalid, 0);
      check_val("t2_p0_rdata", p0_rdata, 0);
      tick();
      check_val("t2_rvalid_low", p1_rvalid, 0);
      check_val("t2_rdata_held", p1_rdata, 32'hDEADBEEF);
      check_val("t2_busy_low", busy, 0);

      // 3: simultaneous requests, counter at 0
      p0_req = 1; p0_we = 1; p0_addr = 32'h10; p0_wdata = 32'h11111111; p0_be = 4'hF;
      p1_req = 1; p1_we = 1; p1_addr = 32'h14; p1_wdata = 32'h22222222; p1_be = 4'hF;
      tick();
      check_val("t3_gnts_first", {p0_gnt, p1_gnt}, 2'b10);
      check_val("t3_addr_first", mem_addr, 32'h10);
      p0_req = 0;
      tick();
      check_val("t3_idle_pass", busy, 0);
      tick();
      check_val("t3_gnts_second", {p0_gnt, p1_gnt}, 2'b01);
      check_val("t3_addr_second", mem_addr, 32'h14);
      check_val("t3_data_second", mem_data_in, 32'h22222222);
      p1_req = 0;
      tick();

      // 4: starvation guard
      p0_req = 1; p0_we = 1; p0_addr = 32'h20; p0_wdata = 32'hA5A5A5A5; p0_be = 4'hF;
      p1_req = 1; p1_we = 1; p1_addr = 32'h24; p1_wdata = 32'h5A5A5A5A; p1_be = 4'hF;
      for (int k = 0; k < 5; k++) begin
         wait_gnt(g0, g1, ok);
         check_val($sformatf("t4_gnt%0d_seen", k), ok, 1);
         check_val($sformatf("t4_gnt%0d_port", k), {g0, g1}, (k == 4) ? 2'b01 : 2'b10);
         if (g1) p1_req = 0;
      end
      p0_req = 0;
      check_val("t4_starve_cleared", 32'(dut.starve_cnt), 0);
      tick(); tick(); tick();
      check_val("t4_drained", busy, 0);
      check_val("t4_mem_p1", mem[9], 32'h5A5A5A5A);

      // 5: byte load returns memory's sign extension untouched
      p1_req = 1; p1_we = 0; p1_addr = 32'h09; p1_be = 4'b0001;
      tick();
      check_val("t5_p1_gnt", p1_gnt, 1);
      check_val("t5_mem_be", mem_byte_enable, 4'b0001);
      check_val("t5_mem_addr", mem_addr, 32'h09);
      p1_req = 0;
      tick(); tick();
      check_val("t5_p1_rvalid", p1_rvalid, 1);
      check_val("t5_p1_rdata", p1_rdata, 32'hFFFFFFBE);
      tick();

      // 6: reset during WAIT of a p0 load
      p0_req = 1; p0_we = 0; p0_addr = 32'h08; p0_be = 4'hF;
      tick();
      check_val("t6_p0_gnt", p0_gnt, 1);
      p0_req = 0;
      tick();
      check_val("t6_wait_busy", busy, 1);
      #2 reset = 1'b0;
      #1;
      check_val("t6_rst_busy", busy, 0);
      check_val("t6_rst_strobes", {mem_read_en, mem_write_en}, 0);
      check_val("t6_rst_addr", mem_addr, 0);
      tick();
      check_val("t6_no_rvalid", p0_rvalid, 0);
      check_val("t6_rdata_cleared", p0_rdata, 0);
      tick();
      reset = 1'b1;
      p0_req = 1; p0_we = 0; p0_addr = 32'h10; p0_be = 4'hF;
      tick();
      check_val("t6_new_gnt", p0_gnt, 1);
      p0_req = 0;
      tick(); tick();
      check_val("t6_new_rvalid", p0_rvalid, 1);
      check_val("t6_new_rdata", p0_rdata, 32'h11111111);
      tick();
      check_val("t6_end_busy", busy, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
